// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types, constants and byte-lane helper for the instruction-memory responder
package instr_mem_pkg;

  localparam int INSTR_W         = 32;
  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte b0 sits at the lowest address and lands in the least significant lane.
  function automatic logic [INSTR_W-1:0] assemble_le(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3
  );
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// rtl/instr_mem_responder_if.sv - CPU fetch and preload port bundle for the instruction-memory responder
interface instr_mem_responder_if #(
  parameter int ADDR_W = 10
);

  logic                              READ;
  logic [ADDR_W-1:0]                 ADDRESS;
  logic                              BUSYWAIT;
  logic [instr_mem_pkg::INSTR_W-1:0] READINST;
  logic                              LOAD_EN;
  logic [ADDR_W-1:0]                 LOAD_ADDR;
  logic [7:0]                        LOAD_DATA;

  modport master (
    output READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
    input  BUSYWAIT, READINST
  );

  modport slave (
    input  READ, ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
    output BUSYWAIT, READINST
  );

endinterface

// File: rtl/instr_mem_responder_byte_ram.sv
// rtl/instr_mem_responder_byte_ram.sv - byte-organised storage, one byte write port, one word read port (read-before-write)
module instr_byte_ram
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [7:0]         wdata,
  input  logic [ADDR_W-3:0]  raddr,
  output logic [INSTR_W-1:0] rword
);

  logic [7:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read: a capture on the same edge as a write sees the old byte.
  assign rword = assemble_le(mem_q[{raddr, 2'd0}], mem_q[{raddr, 2'd1}],
                             mem_q[{raddr, 2'd2}], mem_q[{raddr, 2'd3}]);

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - fixed-latency instruction fetch responder; INSTR_PREFETCH_EN adds a next-word prefetch buffer
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                 CLK,
  input  logic                 RESET,
  instr_mem_responder_if.slave bus
);

  localparam int         WA_W     = ADDR_W - 2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [WA_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0] readinst_q, readinst_d;
  logic [WA_W-1:0]    ram_raddr;
  logic [INSTR_W-1:0] ram_rword;
  logic [WA_W-1:0]    req_word;
  logic               busywait;
  logic               unused_addr_lsb;

`ifdef INSTR_PREFETCH_EN
  logic               pf_valid_q, pf_valid_d;
  logic               pf_busy_q, pf_busy_d;
  logic [3:0]         pf_count_q, pf_count_d;
  logic [WA_W-1:0]    pf_addr_q, pf_addr_d;
  logic [INSTR_W-1:0] pf_data_q, pf_data_d;
  logic               pf_start;
  logic               pf_hit;
`endif

  assign req_word        = bus.ADDRESS[ADDR_W-1:2];
  assign unused_addr_lsb = ^bus.ADDRESS[1:0];

  instr_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .we    (bus.LOAD_EN),
    .waddr (bus.LOAD_ADDR),
    .wdata (bus.LOAD_DATA),
    .raddr (ram_raddr),
    .rword (ram_rword)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    readinst_d = readinst_q;
    busywait   = 1'b0;
    ram_raddr  = addr_q;
`ifdef INSTR_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_busy_d  = pf_busy_q;
    pf_count_d = pf_count_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    pf_start   = 1'b0;
    pf_hit     = pf_valid_q && (pf_addr_q == req_word);
    // The read port is free outside BUSY, so the background fetch borrows it there.
    if (state_q != BUSY) begin
      ram_raddr = pf_addr_q;
    end
    if (pf_busy_q) begin
      if (pf_count_q != 4'd0) begin
        pf_count_d = pf_count_q - 4'd1;
      end else begin
        pf_data_d  = ram_rword;
        pf_valid_d = 1'b1;
        pf_busy_d  = 1'b0;
      end
    end
`endif

    case (state_q)
      IDLE: begin
        if (bus.READ) begin
          busywait = ~RESET;
          state_d  = BUSY;
          count_d  = CNT_INIT;
          addr_d   = req_word;
`ifdef INSTR_PREFETCH_EN
          pf_valid_d = 1'b0;
          pf_busy_d  = 1'b0;
          if (pf_hit) begin
            readinst_d = pf_data_q;
            state_d    = RESP;
            pf_start   = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
        busywait = 1'b1;
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          readinst_d = ram_rword;
          state_d    = RESP;
`ifdef INSTR_PREFETCH_EN
          pf_start   = 1'b1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef INSTR_PREFETCH_EN
    if (pf_start) begin
      pf_addr_d  = addr_d + WA_W'(1);
      pf_count_d = CNT_INIT;
      pf_busy_d  = 1'b1;
      pf_valid_d = 1'b0;
    end
    // A load into the buffered word kills the buffer and any fetch of it in flight.
    if (bus.LOAD_EN && (bus.LOAD_ADDR[ADDR_W-1:2] == pf_addr_d)) begin
      pf_valid_d = 1'b0;
      pf_busy_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      count_q    <= '0;
      addr_q     <= '0;
      readinst_q <= '0;
`ifdef INSTR_PREFETCH_EN
      pf_valid_q <= 1'b0;
      pf_busy_q  <= 1'b0;
      pf_count_q <= '0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      readinst_q <= readinst_d;
`ifdef INSTR_PREFETCH_EN
      pf_valid_q <= pf_valid_d;
      pf_busy_q  <= pf_busy_d;
      pf_count_q <= pf_count_d;
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
`endif
    end
  end

  assign bus.BUSYWAIT = busywait;
  assign bus.READINST = readinst_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - scoreboard bench with a behavioural fetch/prefetch model for instr_mem_responder
module tb_instr_mem_responder;

  localparam int ADDR_W = 10;
  localparam int LAT    = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WORDS  = DEPTH / 4;

  typedef struct {
    logic [31:0] data;
    int          stall;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  instr_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] ref_mem [DEPTH];
  int         checks    = 0;
  int         errors    = 0;
  int         cyc       = 0;
  bit         pf_ok     = 0;
  int         pf_tag    = 0;
  int         pf_ready  = 0;
  bit         prev_bw   = 0;
  int         stall_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < 4; k++) v = v | (32'(ref_mem[4*w+k]) << (8*k));
    return v;
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    ref_mem[a] = d;
    if ((a >> 2) == pf_tag) pf_ok = 0;
  endfunction

  // Monitor: a response is the first BUSYWAIT-low cycle after a stall.
  always @(negedge CLK) begin
    if (RESET) begin
      prev_bw   = 0;
      stall_cnt = 0;
    end else begin
      if (bus.BUSYWAIT) begin
        stall_cnt++;
      end else if (prev_bw) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got response %h, expected none", bus.READINST);
        end else begin
          mon_e = exp_q.pop_front();
          check("readinst", bus.READINST, mon_e.data);
          check("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall));
        end
        stall_cnt = 0;
      end
      prev_bw = bus.BUSYWAIT;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_byte(input int a, input logic [7:0] d);
    bus.LOAD_EN   = 1'b1;
    bus.LOAD_ADDR = ADDR_W'(a);
    bus.LOAD_DATA = d;
    model_write(a, d);
    tick();
    bus.LOAD_EN = 1'b0;
  endtask

  // Reference: a hit needs the buffered next word to have finished LAT cycles after the response.
  task automatic issue(input int a);
    int   w;
    bit   hit;
    exp_t e;
    w   = (a >> 2) % WORDS;
    hit = 0;
`ifdef INSTR_PREFETCH_EN
    hit = pf_ok && (pf_tag == w) && (cyc >= pf_ready);
`endif
    e.data  = ref_word(w);
    e.stall = hit ? 1 : LAT + 1;
    exp_q.push_back(e);
    pf_ok    = 1;
    pf_tag   = (w + 1) % WORDS;
    pf_ready = cyc + e.stall + LAT;
    bus.ADDRESS = ADDR_W'(a);
    bus.READ    = 1'b1;
  endtask

  // mess: 0 none, 1 move ADDRESS to 12 during the stall, 2 random ADDRESS/READ during the stall
  task automatic fetch(input int a, input int mess, input bit keep);
    bit ok;
    ok = 0;
    issue(a);
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge CLK);
      if (!bus.BUSYWAIT) ok = 1;
      else if (k >= 1 && mess == 1) bus.ADDRESS = ADDR_W'(12);
      else if (k >= 1 && mess == 2) begin
        bus.ADDRESS = ADDR_W'($urandom);
        bus.READ    = 1'($urandom_range(0, 1));
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got no response, expected one within 40 cycles");
    end
    tick();
    if (!keep) bus.READ = 1'b0;
  endtask

  initial begin
    int  a;
    int  last_a;
    bit  keep;
    RESET         = 1'b1;
    bus.READ      = 1'b0;
    bus.ADDRESS   = '0;
    bus.LOAD_EN   = 1'b0;
    bus.LOAD_ADDR = '0;
    bus.LOAD_DATA = '0;
    repeat (3) tick();
    check("reset_busywait", 32'(bus.BUSYWAIT), 32'h0);
    check("reset_readinst", bus.READINST, 32'h0);
    RESET = 1'b0;

    for (int i = 0; i < DEPTH; i++) load_byte(i, 8'($urandom));
    load_byte(0, 8'h05); load_byte(1, 8'h00); load_byte(2, 8'h04); load_byte(3, 8'h00);
    load_byte(4, 8'h09); load_byte(5, 8'h00); load_byte(6, 8'h02); load_byte(7, 8'h00);

    fetch(0, 0, 0);
    check("basic_value", bus.READINST, 32'h00040005);

    fetch(0, 0, 1);
    fetch(4, 0, 0);
    check("b2b_value", bus.READINST, 32'h00020009);

    fetch(6, 1, 0);
    check("misaligned_value", bus.READINST, 32'h00020009);

    issue(0);
    repeat (LAT) tick();
    bus.LOAD_EN   = 1'b1;
    bus.LOAD_ADDR = '0;
    bus.LOAD_DATA = 8'hFF;
    model_write(0, 8'hFF);
    tick();
    bus.LOAD_EN = 1'b0;
    @(negedge CLK);
    check("same_edge_resp", 32'(bus.BUSYWAIT), 32'h0);
    check("same_edge_old", bus.READINST, 32'h00040005);
    tick();
    bus.READ = 1'b0;
    fetch(0, 0, 0);
    check("same_edge_new", bus.READINST, 32'h000400FF);

    bus.ADDRESS = '0;
    bus.READ    = 1'b1;
    tick();
    tick();
    #2 RESET = 1'b1;
    #1;
    check("rst_mid_busywait", 32'(bus.BUSYWAIT), 32'h0);
    check("rst_mid_readinst", bus.READINST, 32'h0);
    bus.READ = 1'b0;
    pf_ok    = 0;
    tick();
    RESET = 1'b0;
    repeat (8) tick();

    fetch(0, 0, 0);
    repeat (6) tick();
    fetch(4, 0, 0);
    check("pf_hit_value", bus.READINST, 32'h00020009);
    fetch(0, 0, 0);
    repeat (6) tick();
    load_byte(5, 8'h3C);
    fetch(4, 0, 0);
    check("pf_inval_value", bus.READINST, 32'h00023C09);

    last_a = 4;
    keep   = 0;
    for (int n = 0; n < 150; n++) begin
      if (!keep) begin
        repeat ($urandom_range(0, 3)) begin
          if ($urandom_range(0, 1) == 1)
            load_byte(((last_a + 4) % DEPTH) + int'($urandom_range(0, 3)), 8'($urandom));
          else
            load_byte(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
        end
        repeat ($urandom_range(0, 7)) tick();
      end
      a    = ($urandom_range(0, 1) == 1) ? (last_a + 4) % DEPTH : int'($urandom_range(0, DEPTH - 1));
      keep = (n < 149) && ($urandom_range(0, 3) == 0);
      fetch(a, ($urandom_range(0, 1) == 1) ? 2 : 0, keep);
      last_a = a & ~3;
    end

    bus.READ = 1'b0;
    repeat (10) tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Synthesizable instruction-memory responder: the memory end of the CPU fetch interface.
- The CPU presents a byte address (PC) and read strobe; the block stalls it with BUSYWAIT for a fixed latency, then returns one little-endian 32-bit instruction word.
- Replaces the bench's zero-state combinational fetch in the cache/memory lab CPU; storage is byte-organised, 1024 x 8.
- A byte-wide load port preloads program content.

Parameters:
- ADDR_W, 10, byte-address width; storage depth is 2**ADDR_W bytes.
- LATENCY, 4, clock cycles BUSYWAIT stays high per fetch; legal range 1..15.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- READ  input  1  fetch request from CPU, held high until the response cycle.
- ADDRESS  input  ADDR_W  byte address of instruction; bits [1:0] ignored (word-aligned).
- BUSYWAIT  output  1  high while a fetch is outstanding; CPU holds PC and READ.
- READINST  output  32  fetched instruction, valid in the RESP cycle and held until the next capture.
- LOAD_EN  input  1  byte write strobe for preloading.
- LOAD_ADDR  input  ADDR_W  byte address for load.
- LOAD_DATA  input  8  byte to write.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, count=0, BUSYWAIT=0, READINST=32'h0. An in-flight fetch is aborted with no response. Memory contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If READ=1: BUSYWAIT=1 combinationally in the same cycle.
  - At the next edge: go to BUSY with count=LATENCY-1 and latch word address ADDRESS[ADDR_W-1:2].
- BUSY:
  - BUSYWAIT=1.
  - If count>0: decrement.
  - If count==0: capture READINST={mem[a+3],mem[a+2],mem[a+1],mem[a]} (a = latched address<<2), then go to RESP.
  - Total stall = LATENCY+1 cycles, from the first READ cycle to the first cycle with BUSYWAIT=0.
- RESP:
  - BUSYWAIT=0 for exactly one cycle; the CPU samples READINST and advances PC at this edge.
  - Next state is IDLE. A READ still high in the following IDLE cycle starts a new fetch at the then-current ADDRESS.
- READ dropped while in BUSY: the fetch completes anyway (RESP still occurs); no abort except via RESET.
- ADDRESS changes during BUSY: ignored, the latched address is used.
- Loads:
  - LOAD_EN writes mem[LOAD_ADDR]=LOAD_DATA at the rising edge, in any state.
  - If a load and a capture occur on the same edge, the capture uses the pre-write byte (read-before-write).
- Wrap-around: byte addresses a+1..a+3 never overflow because a is word-aligned; ADDRESS bits above ADDR_W do not exist.
- READINST changes only at capture edges or on reset.

Optional Feature:
- Macro: INSTR_PREFETCH_EN.
- With the macro defined:
  - On entering RESP, the block fetches word a+4 (modulo depth) in the background into a one-word buffer with its tag, taking LATENCY cycles.
  - An IDLE READ whose word address matches a valid buffer tag goes straight to RESP next edge (BUSYWAIT high 1 cycle). Buffer contents move to READINST and the next prefetch starts.
  - A miss discards the buffer, waiting out or aborting any prefetch in progress, and follows the normal path.
  - A LOAD to any byte of the buffered word invalidates the buffer.
  - RESET invalidates the buffer.
- Without the macro: no buffer, and every fetch takes the full LATENCY stall.

Decomposition:
- Shared package instr_mem_pkg:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
  - INSTR_W=32 and default LATENCY.
  - Little-endian byte-lane assembly function.
- One sub-module, instr_byte_ram: 2**ADDR_W x 8 array, one write port, four-byte word read port with read-before-write semantics.
- The FSM, counter and prefetch buffer live in the top module.

Test Plan:
- Reset mid-fetch: READ=1, ADDRESS=0, assert RESET at cycle 2 -> BUSYWAIT=0 and READINST=0 immediately (asynchronous); no RESP pulse afterwards.
- Basic fetch: load bytes 05,00,04,00 at 0..3, READ=1 ADDRESS=0 -> BUSYWAIT high 5 cycles (LATENCY=4), then READINST=32'h00040005 with BUSYWAIT=0 for exactly one cycle.
- Back-to-back: fetch 0 then 4 (word 32'h00020009) with READ held high -> two stalls of 5 cycles, READINST sequence 00040005 then 00020009, and exactly one IDLE cycle between them.
- Misaligned/hold: ADDRESS=6 changed to 12 during BUSY -> returns word at byte 4 (bits [1:0] dropped, latched address used).
- Same-edge load: LOAD_EN writes byte 8'hFF to address 0 on the capture edge -> READINST returns old 00040005; the next fetch returns 000400FF.
- Prefetch (INSTR_PREFETCH_EN): after the fetch of 0 completes, wait 6 cycles, then READ ADDRESS=4 -> BUSYWAIT high 1 cycle, READINST=00020009. Repeat with LOAD to byte 5 first -> full 5-cycle stall.
